// File: rtl/nonmax_suppress.sv
// nonmax_suppress
//
// Non-maximum suppression stage of the Canny pipeline. Takes a 3x3
// gradient-magnitude window plus the quantised gradient direction of the
// centre pixel, and keeps the centre magnitude only if it is a local maximum
// along that direction. Outputs carry the output-image raster position and a
// one-cycle end-of-frame strobe. Two register stages, one window per clock,
// no back-pressure.
//
// Optional feature (compile-time macro NONMAX_BORDER_ZERO_EN):
//   when defined, out_mag is forced to 0 on the outermost ring of the output
//   image to suppress edges caused by window-buffer warm-up.
//
// Parameters:
//   WIDTH, HEIGHT - input image size in pixels
//   R_KERNEL      - window radius; output image is (WIDTH-2R) x (HEIGHT-2R)
//   DATA_W        - magnitude width
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    window valid
//   win0..win8  window, row-major, win4 is the centre
//   direction   0=0deg, 1=45deg, 2=90deg, 3=135deg
//   out_valid   out_mag/out_col/out_row valid
//   out_mag     suppressed magnitude (centre value or 0)
//   out_col     output-image column
//   out_row     output-image row
//   frame_done  pulses with the last pixel of a frame

module nonmax_suppress #(
  parameter int WIDTH    = 506,
  parameter int HEIGHT   = 506,
  parameter int R_KERNEL = 1,
  parameter int DATA_W   = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] win0,
  input  logic [DATA_W-1:0] win1,
  input  logic [DATA_W-1:0] win2,
  input  logic [DATA_W-1:0] win3,
  input  logic [DATA_W-1:0] win4,
  input  logic [DATA_W-1:0] win5,
  input  logic [DATA_W-1:0] win6,
  input  logic [DATA_W-1:0] win7,
  input  logic [DATA_W-1:0] win8,
  input  logic [1:0]        direction,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_mag,
  output logic [9:0]        out_col,
  output logic [9:0]        out_row,
  output logic              frame_done
);

  localparam int OUT_W = WIDTH - 2 * R_KERNEL;
  localparam int OUT_H = HEIGHT - 2 * R_KERNEL;
  localparam logic [9:0] COL_LAST = 10'(OUT_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(OUT_H - 1);

  // Neighbour pair along the gradient direction.
  logic [DATA_W-1:0] nb_a;
  logic [DATA_W-1:0] nb_b;

  always_comb begin
    nb_a = win3;
    nb_b = win5;
    case (direction)
      2'd0: begin
        nb_a = win3;
        nb_b = win5;
      end
      2'd1: begin
        nb_a = win6;
        nb_b = win2;
      end
      2'd2: begin
        nb_a = win1;
        nb_b = win7;
      end
      default: begin
        nb_a = win0;
        nb_b = win8;
      end
    endcase
  end

  // Raster position of the window currently on the inputs.
  logic [9:0] col_cnt;
  logic [9:0] row_cnt;
  logic       at_eol;
  logic       at_eof;

  assign at_eol = (col_cnt == COL_LAST);
  assign at_eof = at_eol && (row_cnt == ROW_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (at_eol) begin
        col_cnt <= '0;
        row_cnt <= at_eof ? 10'd0 : row_cnt + 10'd1;
      end else begin
        col_cnt <= col_cnt + 10'd1;
      end
    end
  end

  // Stage 1: centre, selected neighbours, position and last-pixel tag.
  logic              s1_valid;
  logic [DATA_W-1:0] s1_ctr;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [9:0]        s1_col;
  logic [9:0]        s1_row;
  logic              s1_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_ctr   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ctr  <= win4;
        s1_a    <= nb_a;
        s1_b    <= nb_b;
        s1_col  <= col_cnt;
        s1_row  <= row_cnt;
        s1_last <= at_eof;
      end
    end
  end

  // Keep rule: strict against a, non-strict against b, so a two-pixel
  // plateau produces exactly one surviving edge pixel.
  logic              keep;
  logic [DATA_W-1:0] mag_next;

  assign keep = (s1_ctr > s1_a) && (s1_ctr >= s1_b);

`ifdef NONMAX_BORDER_ZERO_EN
  logic on_border;
  assign on_border = (s1_col == 10'd0) || (s1_col == COL_LAST) ||
                     (s1_row == 10'd0) || (s1_row == ROW_LAST);
  assign mag_next  = (keep && !on_border) ? s1_ctr : '0;
`else
  assign mag_next  = keep ? s1_ctr : '0;
`endif

  // Stage 2: data outputs hold their value through bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_mag    <= '0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      frame_done <= s1_valid && s1_last;
      if (s1_valid) begin
        out_mag <= mag_next;
        out_col <= s1_col;
        out_row <= s1_row;
      end
    end
  end

endmodule

// File: tb/tb_nonmax_suppress.sv
// Testbench for nonmax_suppress with a 6x6 input image (4x4 output).
// Table-driven keep-rule vectors, directed latency / reset sequences and
// randomized frames, all scored against a position-indexed reference model.

module tb_nonmax_suppress;

  localparam int W     = 6;
  localparam int H     = 6;
  localparam int DW    = 11;
  localparam int OUT_W = 4;
  localparam int OUT_H = 4;
  localparam int NPIX  = OUT_W * OUT_H;

  localparam int NA [4] = '{3, 6, 1, 0};
  localparam int NB [4] = '{5, 2, 7, 8};

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic [8:0][DW-1:0]  win_bus = '0;
  logic [1:0]          direction = 2'd0;
  logic                out_valid;
  logic [DW-1:0]       out_mag;
  logic [9:0]          out_col;
  logic [9:0]          out_row;
  logic                frame_done;

  always #5 clk = ~clk;

  nonmax_suppress #(
    .WIDTH(W), .HEIGHT(H), .R_KERNEL(1), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .win0(win_bus[0]), .win1(win_bus[1]), .win2(win_bus[2]),
    .win3(win_bus[3]), .win4(win_bus[4]), .win5(win_bus[5]),
    .win6(win_bus[6]), .win7(win_bus[7]), .win8(win_bus[8]),
    .direction(direction),
    .out_valid(out_valid), .out_mag(out_mag), .out_col(out_col),
    .out_row(out_row), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [DW-1:0] mag;
    logic [9:0]    col;
    logic [9:0]    row;
    logic          last;
  } exp_t;

  typedef struct packed {
    logic [1:0]         dir;
    logic [8:0][DW-1:0] w;
    logic [DW-1:0]      exp_mag;
  } vec_t;

  exp_t exp_q[$];
  exp_t last_exp = '0;
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   pix_idx = 0;
  int   beat_cnt = 0;
  int   fd_cnt = 0;
  int   nz_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic bit is_border(input int col, input int row);
`ifdef NONMAX_BORDER_ZERO_EN
    return (col == 0) || (col == OUT_W - 1) || (row == 0) || (row == OUT_H - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: position from the count of accepted windows since reset,
  // magnitude from the local-maximum rule along the chosen direction.
  function automatic exp_t model(input logic [8:0][DW-1:0] w, input logic [1:0] d,
                                 input int idx);
    exp_t e;
    int p, col, row;
    logic [DW-1:0] c, a, b;
    p   = idx % NPIX;
    col = p % OUT_W;
    row = p / OUT_W;
    c   = w[4];
    a   = w[NA[d]];
    b   = w[NB[d]];
    e.mag  = ((c > a) && (c >= b) && !is_border(col, row)) ? c : '0;
    e.col  = 10'(col);
    e.row  = 10'(row);
    e.last = (p == NPIX - 1);
    return e;
  endfunction

  // Present one valid window for exactly one clock; called at posedge+1.
  task automatic applyStimulus(input logic [8:0][DW-1:0] w, input logic [1:0] d,
                               input bit use_tab, input logic [DW-1:0] tab_mag);
    exp_t e;
    win_bus   = w;
    direction = d;
    in_valid  = 1'b1;
    e = model(w, d, pix_idx);
    if (use_tab) e.mag = is_border(int'(e.col), int'(e.row)) ? '0 : tab_mag;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    pix_idx++;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    exp_q.delete();
    pix_idx  = 0;
    last_exp = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic checkDrained(input string name);
    idle(4);
    checkOutput(name, exp_q.size(), 0);
  endtask

  // Scoreboard: every beat is matched in order; bubbles must hold the
  // previous beat's data and never carry frame_done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        beat_cnt++;
        if (out_mag != '0) nz_cnt++;
        if (frame_done) fd_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("beat_mag", out_mag, mon_e.mag);
          checkOutput("beat_col", out_col, mon_e.col);
          checkOutput("beat_row", out_row, mon_e.row);
          checkOutput("beat_frame_done", frame_done, mon_e.last);
          last_exp = mon_e;
        end
      end else begin
        checkOutput("bubble_frame_done", frame_done, 0);
        checkOutput("bubble_hold_mag", out_mag, last_exp.mag);
        checkOutput("bubble_hold_col", out_col, last_exp.col);
        checkOutput("bubble_hold_row", out_row, last_exp.row);
      end
    end
  end

  vec_t tab[22];

  initial begin
    logic [8:0][DW-1:0] w;
    int n;

    // Keep-rule table: plateaus plus per-direction neighbour sweeps with
    // every non-selected neighbour parked at full scale.
    w = '0; w[1] = 11'd9; w[4] = 11'd9; w[7] = 11'd3;
    tab[0] = '{dir: 2'd2, w: w, exp_mag: 11'd0};
    w = '0; w[1] = 11'd3; w[4] = 11'd9; w[7] = 11'd9;
    tab[1] = '{dir: 2'd2, w: w, exp_mag: 11'd9};
    n = 2;
    for (int d = 0; d < 4; d++) begin
      for (int v = 0; v < 5; v++) begin
        w = {9{11'd2047}};
        w[4] = 11'd100;
        w[NA[d]] = 11'd99;
        w[NB[d]] = 11'd99;
        case (v)
          1: w[NA[d]] = 11'd101;
          2: w[NB[d]] = 11'd101;
          3: w[NA[d]] = 11'd100;
          4: w[NB[d]] = 11'd100;
          default: ;
        endcase
        tab[n] = '{dir: 2'(d), w: w,
                   exp_mag: (v == 0 || v == 4) ? 11'd100 : 11'd0};
        n++;
      end
    end

    // Reset state.
    idle(3);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_mag", out_mag, 0);
    checkOutput("reset_out_col", out_col, 0);
    checkOutput("reset_out_row", out_row, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    reset_n = 1'b1;
    idle(1);

    // First window: visible two edges after it is presented, not earlier.
    w = '0; w[3] = 11'd5; w[4] = 11'd9; w[5] = 11'd7;
    applyStimulus(w, 2'd0, 1'b1, 11'd9);
    checkOutput("latency_not_early", out_valid, 0);
    idle(1);
    checkOutput("first_out_valid", out_valid, 1);
    checkOutput("first_out_mag", out_mag, 9);
    checkOutput("first_out_col", out_col, 0);
    checkOutput("first_out_row", out_row, 0);
    idle(1);
    checkOutput("first_single_beat", out_valid, 0);
    checkDrained("first_drain");

    // Table vectors with occasional bubbles.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(tab[i].w, tab[i].dir, 1'b1, tab[i].exp_mag);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    checkDrained("table_drain");

    // Two random frames, back-to-back allowed, random bubbles.
    pulseReset();
    beat_cnt = 0;
    fd_cnt   = 0;
    for (int i = 0; i < 2 * NPIX; i++) begin
      for (int k = 0; k < 9; k++)
        w[k] = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 7));
      applyStimulus(w, 2'($urandom_range(0, 3)), 1'b0, '0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    checkDrained("frames_drain");
    checkOutput("frames_beat_count", beat_cnt, 2 * NPIX);
    checkOutput("frames_done_count", fd_cnt, 2);

    // Abort a frame at pixel (2,1); it must never report frame_done.
    pulseReset();
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 9; k++) w[k] = 11'($urandom_range(0, 50));
      applyStimulus(w, 2'($urandom_range(0, 3)), 1'b0, '0);
    end
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    pix_idx  = 0;
    last_exp = '0;
    #1;
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_out_mag", out_mag, 0);
    checkOutput("abort_out_col", out_col, 0);
    checkOutput("abort_out_row", out_row, 0);
    checkOutput("abort_frame_done", frame_done, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    fd_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 9; k++) w[k] = 11'($urandom_range(0, 50));
      applyStimulus(w, 2'($urandom_range(0, 3)), 1'b0, '0);
    end
    checkDrained("abort_drain");
    checkOutput("abort_no_frame_done", fd_cnt, 0);

    // Frame where every window is a local maximum.
    pulseReset();
    nz_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      w = '0;
      w[4] = 11'd100;
      applyStimulus(w, 2'($urandom_range(0, 3)), 1'b0, '0);
    end
    checkDrained("border_drain");
`ifdef NONMAX_BORDER_ZERO_EN
    checkOutput("border_nonzero_count", nz_cnt, 4);
`else
    checkOutput("border_nonzero_count", nz_cnt, NPIX);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
